// File: rtl/seq_onehot_decoder_pkg.sv
// Shared constants and helpers for the one-hot decoder / scan walker.
package seq_onehot_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_onehot_decoder_if.sv
// Control and output bundle of seq_onehot_decoder; master drives controls, slave is the decoder.
interface seq_onehot_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_N = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic [OUT_N-1:0] d;
    logic [SEL_W-1:0] idx;
    logic             valid;
    logic             wrap;

    modport master (
        output en, mode, load, sel,
        input  d, idx, valid, wrap
    );

    modport slave (
        input  en, mode, load, sel,
        output d, idx, valid, wrap
    );

endinterface

// File: rtl/seq_onehot_decoder_onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  en_i,
    output logic [2**SEL_W-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered one-hot decoder with DIRECT select and self-sequencing SCAN mode.
module seq_onehot_decoder
    import seq_onehot_decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    seq_onehot_decoder_if.slave bus
);

    localparam int OUT_N = 2 ** SEL_W;
    localparam int PW    = (clog2(STEP) < 1) ? 1 : clog2(STEP);

    localparam logic [PW-1:0]    PRE_TC   = PW'(STEP - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_N - 1);

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        idx_d   = idx_q;
        pre_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (bus.en) begin
            valid_d = 1'b1;
            if (bus.mode == MODE_DIRECT) begin
                idx_d = bus.sel;
            end else if (bus.load) begin
                idx_d = bus.sel;
            end else if (pre_q == PRE_TC) begin
                // Roll-over to 0 is the only advance that flags wrap.
                idx_d  = idx_q + SEL_W'(1);
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            pre_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel_i    (idx_q),
        .en_i     (valid_q),
        .onehot_o (bus.d)
    );

    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Self-checking bench for seq_onehot_decoder: vector table, corner sequences, random vs model.
module tb_seq_onehot_decoder;
    import seq_onehot_decoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_onehot_decoder_if #(.SEL_W(3)) if_m ();
    seq_onehot_decoder_if #(.SEL_W(3)) if_s ();
    seq_onehot_decoder_if #(.SEL_W(1)) if_1 ();
    seq_onehot_decoder_if #(.SEL_W(6)) if_6 ();

    seq_onehot_decoder #(.SEL_W(3), .STEP(4)) dut_m (.clk(clk), .rst(rst), .bus(if_m));
    seq_onehot_decoder #(.SEL_W(3), .STEP(1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    seq_onehot_decoder #(.SEL_W(1), .STEP(4)) dut_1 (.clk(clk), .rst(rst), .bus(if_1));
    seq_onehot_decoder #(.SEL_W(6), .STEP(4)) dut_6 (.clk(clk), .rst(rst), .bus(if_6));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic       load;
        logic [2:0] sel;
        logic [7:0] d;
        logic [2:0] idx;
        logic       v;
        logic       w;
    } vec_t;

    vec_t tv[$];

    task automatic addv(input logic en, input logic mode, input logic load, input logic [2:0] sel,
                        input logic [7:0] d, input logic [2:0] idx, input logic v, input logic w);
        vec_t x;
        x.en = en; x.mode = mode; x.load = load; x.sel = sel;
        x.d = d; x.idx = idx; x.v = v; x.w = w;
        tv.push_back(x);
    endtask

    // Behavioural model: position plus cycles spent at it, per DUT (0 = STEP 4, 1 = STEP 1).
    int   m_pos[2];
    int   m_age[2];
    int   m_step[2];
    logic m_v[2];
    logic m_w[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pos[m] = 0; m_age[m] = 0; m_v[m] = 1'b0; m_w[m] = 1'b0;
        end
        m_step[0] = 4;
        m_step[1] = 1;
    endtask

    task automatic model(input int m, input logic en, input logic mode, input logic load, input int sel);
        m_w[m] = 1'b0;
        if (!en) begin
            m_v[m] = 1'b0;
            m_age[m] = 0;
        end else begin
            m_v[m] = 1'b1;
            if (mode == 1'b0 || load) begin
                m_pos[m] = sel;
                m_age[m] = 0;
            end else if (m_age[m] + 1 == m_step[m]) begin
                m_w[m]   = (m_pos[m] == 7);
                m_pos[m] = (m_pos[m] + 1) % 8;
                m_age[m] = 0;
            end else begin
                m_age[m] = m_age[m] + 1;
            end
        end
    endtask

    task automatic drive_all_idle();
        if_m.en = 0; if_m.mode = 0; if_m.load = 0; if_m.sel = '0;
        if_s.en = 0; if_s.mode = 0; if_s.load = 0; if_s.sel = '0;
        if_1.en = 0; if_1.mode = 0; if_1.load = 0; if_1.sel = '0;
        if_6.en = 0; if_6.mode = 0; if_6.load = 0; if_6.sel = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] rsel;
        logic       ren, rmode, rload;

        drive_all_idle();
        rst = 1'b1;
        #2;
        check("rst_d",     if_m.d, 0);
        check("rst_idx",   if_m.idx, 0);
        check("rst_valid", if_m.valid, 0);
        check("rst_wrap",  if_m.wrap, 0);
        check("rst_d6",    if_6.d, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;

        // Table: DIRECT, en drop, scan dwell and wrap, load at terminal count, re-enable, mode swaps.
        addv(1,0,0,5, 8'h20,5,1,0);
        addv(0,0,0,5, 8'h00,5,0,0);
        addv(1,1,1,6, 8'h40,6,1,0);
        for (int i = 0; i < 3; i++) addv(1,1,0,0, 8'h40,6,1,0);
        for (int i = 0; i < 4; i++) addv(1,1,0,0, 8'h80,7,1,0);
        addv(1,1,0,0, 8'h01,0,1,1);
        for (int i = 0; i < 3; i++) addv(1,1,0,0, 8'h01,0,1,0);
        addv(1,1,0,0, 8'h02,1,1,0);
        addv(1,1,1,7, 8'h80,7,1,0);
        for (int i = 0; i < 3; i++) addv(1,1,0,0, 8'h80,7,1,0);
        addv(1,1,1,3, 8'h08,3,1,0);
        for (int i = 0; i < 3; i++) addv(1,1,0,0, 8'h08,3,1,0);
        addv(1,1,0,0, 8'h10,4,1,0);
        addv(1,1,1,0, 8'h01,0,1,0);
        addv(1,1,0,0, 8'h01,0,1,0);
        addv(0,1,0,0, 8'h00,0,0,0);
        for (int i = 0; i < 3; i++) addv(1,1,0,0, 8'h01,0,1,0);
        addv(1,1,0,0, 8'h02,1,1,0);
        addv(1,0,0,4, 8'h10,4,1,0);
        for (int i = 0; i < 3; i++) addv(1,1,0,0, 8'h10,4,1,0);
        addv(1,1,0,0, 8'h20,5,1,0);

        for (int i = 0; i < tv.size(); i++) begin
            if_m.en = tv[i].en; if_m.mode = tv[i].mode;
            if_m.load = tv[i].load; if_m.sel = tv[i].sel;
            tick();
            check($sformatf("vec%0d_d", i),     if_m.d, tv[i].d);
            check($sformatf("vec%0d_idx", i),   if_m.idx, tv[i].idx);
            check($sformatf("vec%0d_valid", i), if_m.valid, tv[i].v);
            check($sformatf("vec%0d_wrap", i),  if_m.wrap, tv[i].w);
        end

        // STEP=1: walk every cycle, wrap every 8 cycles.
        if_s.en = 1; if_s.mode = MODE_SCAN; if_s.load = 1; if_s.sel = 3'd0;
        tick();
        check("s1_start_d", if_s.d, 64'h1);
        if_s.load = 0;
        for (int k = 1; k < 24; k++) begin
            tick();
            check($sformatf("s1_d%0d", k),    if_s.d, 64'(1) << (k % 8));
            check($sformatf("s1_idx%0d", k),  if_s.idx, k % 8);
            check($sformatf("s1_wrap%0d", k), if_s.wrap, (k % 8 == 0) ? 1 : 0);
        end
        if_s.en = 0;

        // Asynchronous reset mid-dwell at idx 4, then restart in SCAN.
        if_m.en = 1; if_m.mode = MODE_SCAN; if_m.load = 1; if_m.sel = 3'd4;
        tick();
        if_m.load = 0;
        tick();
        check("pre_rst_idx", if_m.idx, 4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_d",     if_m.d, 0);
        check("async_rst_idx",   if_m.idx, 0);
        check("async_rst_valid", if_m.valid, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("post_rst_d%0d", k),     if_m.d, 64'h01);
            check($sformatf("post_rst_valid%0d", k), if_m.valid, 1);
        end
        tick();
        check("post_rst_adv_d", if_m.d, 64'h02);
        if_m.en = 0;

        // Exhaustive DIRECT sweeps on the narrow and wide builds.
        if_1.en = 1; if_1.mode = MODE_DIRECT;
        if_6.en = 1; if_6.mode = MODE_DIRECT;
        for (int s = 0; s < 2; s++) begin
            if_1.sel = 1'(s);
            tick();
            check($sformatf("w1_d%0d", s),   if_1.d, 64'(1) << s);
            check($sformatf("w1_idx%0d", s), if_1.idx, s);
        end
        for (int s = 0; s < 64; s++) begin
            if_6.sel = 6'(s);
            tick();
            check($sformatf("w6_d%0d", s),   if_6.d, 64'(1) << s);
            check($sformatf("w6_idx%0d", s), if_6.idx, s);
        end
        drive_all_idle();

        // Random stimulus on both SEL_W=3 builds against the model.
        do_reset();
        model_reset();
        rmode = 1'b1;
        for (int c = 0; c < 500; c++) begin
            ren   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) rmode = ~rmode;
            rload = ($urandom_range(0, 7) == 0);
            rsel  = 3'($urandom_range(0, 7));
            if_m.en = ren; if_m.mode = rmode; if_m.load = rload; if_m.sel = rsel;
            if_s.en = ren; if_s.mode = rmode; if_s.load = rload; if_s.sel = rsel;
            model(0, ren, rmode, rload, int'(rsel));
            model(1, ren, rmode, rload, int'(rsel));
            tick();
            check($sformatf("rnd%0d_m_d", c),     if_m.d, m_v[0] ? (64'(1) << m_pos[0]) : 64'h0);
            check($sformatf("rnd%0d_m_idx", c),   if_m.idx, m_pos[0]);
            check($sformatf("rnd%0d_m_valid", c), if_m.valid, m_v[0]);
            check($sformatf("rnd%0d_m_wrap", c),  if_m.wrap, m_w[0]);
            check($sformatf("rnd%0d_s_d", c),     if_s.d, m_v[1] ? (64'(1) << m_pos[1]) : 64'h0);
            check($sformatf("rnd%0d_s_idx", c),   if_s.idx, m_pos[1]);
            check($sformatf("rnd%0d_s_valid", c), if_s.valid, m_v[1]);
            check($sformatf("rnd%0d_s_wrap", c),  if_s.wrap, m_w[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
